scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Free-running or single-shot channel scanner that produces the 3-bit address and enable driving the team's 3-to-8 decoder stage directly. It steps through the enabled channels of an 8-bit mask. Each channel is held for a programmable dwell time. It sits immediately upstream of the decoder in LED-row / keypad-column scan paths. It also provides busy, per-channel tick and end-of-frame done status to the controlling logic.

## Interface
- DWELL_W, 8, width of dwell-count input and internal dwell counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; ignored while busy
- stop  in  1  one-cycle abort request; returns block to idle
- mode_cont  in  1  1 = continuous scanning, 0 = single frame; sampled at start
- dwell  in  DWELL_W  cycles per channel minus one; sampled at start
- ch_mask  in  8  per-channel enable, bit i = channel i
- A  out  3  decoder address (A[0] = LSB), registered
- EN  out  1  decoder enable, registered
- tick  out  1  pulse on last dwell cycle of each channel
- busy  out  1  high from first scan cycle until return to idle
- done  out  1  one-cycle pulse when a single-shot frame completes (or empty-mask start)

## Operation
- Reset values: A=0, EN=0, tick=0, busy=0, done=0; state IDLE, counters 0.
- States: IDLE, SCAN, GAP (GAP exists only with SCAN_BLANK_EN).
- IDLE: A=0, EN=0.
  - On start with latched mask nonzero: latch dwell, mode_cont and ch_mask.
  - A = lowest set mask bit, go SCAN, counter=0.
- start with ch_mask==0: stay IDLE, pulse done, busy stays 0.
- SCAN: EN=1, busy=1.
  - Counter increments each cycle.
  - When counter==latched dwell: tick=1 that cycle, channel complete.
- Next channel: lowest set bit strictly above current A.
- If none exists, the frame ends:
  - mode_cont=1: re-latch ch_mask from the port and select its lowest set bit. If the new mask is 0, go IDLE without done.
  - mode_cont=0: go IDLE, pulse done.
- Mask changes mid-frame have no effect. They are picked up only at start or at a continuous-mode frame wrap.
- stop in any state: next cycle IDLE, EN=0, A=0, busy=0, no done, no tick.
- start+stop same cycle: stop wins, block stays/returns IDLE.
- start while busy: ignored.
- rst mid-operation: all outputs take reset values at that edge.

## Timing
- start sampled at edge k → EN=1, A=first channel, busy=1 visible after edge k (cycle k+1).
- Each channel: EN high for dwell+1 consecutive cycles. dwell=0 gives 1 cycle per channel.
- tick coincides with the final EN-high cycle of each channel.
- A changes only on the cycle after tick, never while a channel is mid-dwell.
- Single-shot frame with N enabled channels:
  - EN is high N×(dwell+1) cycles, plus N−1 GAP cycles with the macro.
  - done, EN=0 and busy=0 appear together in the cycle after the last tick.
- Continuous mode: no dead cycle at the wrap without the macro. Wrap A: last channel → first channel.
- Outputs are glitch-free registered values, with no combinational path from inputs to outputs.

## Configuration
- SCAN_BLANK_EN defined:
  - After each channel's tick, one GAP cycle: EN=0, A already holds the next channel, busy=1.
  - Then SCAN resumes. This applies at continuous-mode wraps too.
  - No GAP after the final channel of a single-shot frame.
  - stop during GAP behaves as in SCAN.
- Undefined: GAP state absent; SCAN→SCAN transitions directly, EN stays high across channel changes.

## Test plan
- Reset: hold rst 3 cycles mid-scan → A=0, EN=0, busy=0, tick=0, done=0 on the edge after rst sampled.
- Single-shot, ch_mask=8'hFF, dwell=2, mode_cont=0 → A steps 0..7, each held 3 cycles with EN=1, 8 ticks.
  - done pulses at cycle 25 after start.
  - With SCAN_BLANK_EN: A=1..7 each preceded by an EN=0 cycle, done at cycle 32.
- Sparse mask 8'b1010_0100, dwell=0, mode_cont=1 → A sequence 2,5,7,2,5,7…, one cycle each, no done.
  - Writing ch_mask=8'h01 mid-frame takes effect only after A=7 completes.
- start with ch_mask=0 → done pulse one cycle later, EN never asserts, busy stays 0.
- stop at 2nd dwell cycle of channel 3 → next cycle EN=0, A=0, busy=0, no done; subsequent start restarts at lowest enabled channel.
- Simultaneous start+stop from IDLE → remains IDLE. start asserted while busy → sequence unchanged, frame length unaffected.

Source files
------------

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Steps through the enabled channels of an 8-bit mask and drives the 3-bit
// address and enable of a downstream 3-to-8 decoder. Each channel is held for
// dwell+1 cycles. The block can run a single frame or scan continuously, and
// it reports busy, a per-channel tick and an end-of-frame done pulse.
//
// Configuration macro:
//   SCAN_BLANK_EN - when defined, a one-cycle blanking gap (EN=0, A already at
//                   the next channel) is inserted after every channel's tick,
//                   except after the final channel of a single-shot frame.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle frame request (ignored while busy)
//   stop       in   one-cycle abort, wins over start
//   mode_cont  in   1 = continuous, 0 = single frame (sampled at start)
//   dwell      in   cycles per channel minus one (sampled at start)
//   ch_mask    in   channel enables, bit i = channel i
//   A          out  decoder address, registered
//   EN         out  decoder enable, registered
//   tick       out  high on the last dwell cycle of each channel
//   busy       out  high while a frame is running
//   done       out  one-cycle pulse at single-shot frame end / empty-mask start
// -----------------------------------------------------------------------------
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         ch_mask,
    output logic [2:0]         A,
    output logic               EN,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1
`ifdef SCAN_BLANK_EN
        ,
        ST_GAP  = 2'd2
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         a_q, a_d;
    logic               en_q, en_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [7:0]         mask_q, mask_d;

    // {found, index} of the lowest set bit of m.
    function automatic logic [3:0] lowest_set(input logic [7:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // Latched-mask channels strictly above the current address.
    logic [7:0] above_mask;
    for (genvar gi = 0; gi < 8; gi++) begin : g_above
        assign above_mask[gi] = mask_q[gi] && (3'(gi) > a_q);
    end

    logic [3:0]         next_sel;
    logic [3:0]         port_sel;
    logic [DWELL_W-1:0] cnt_inc;

    assign next_sel = lowest_set(above_mask);
    assign port_sel = lowest_set(ch_mask);
    assign cnt_inc  = cnt_q + DWELL_W'(1);

    logic       advance;
    logic [2:0] adv_a;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        en_d    = en_q;
        tick_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        mask_d  = mask_q;
        advance = 1'b0;
        adv_a   = a_q;

        if (stop) begin
            state_d = ST_IDLE;
            a_d     = 3'd0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    a_d    = 3'd0;
                    en_d   = 1'b0;
                    busy_d = 1'b0;
                    if (start) begin
                        if (port_sel[3]) begin
                            dwell_d = dwell;
                            cont_d  = mode_cont;
                            mask_d  = ch_mask;
                            a_d     = port_sel[2:0];
                            cnt_d   = '0;
                            state_d = ST_SCAN;
                            en_d    = 1'b1;
                            busy_d  = 1'b1;
                            // tick is registered, so it is decided for the
                            // cycle being entered, not the current one.
                            tick_d  = (dwell == '0);
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end

                ST_SCAN: begin
                    if (cnt_q == dwell_q) begin
                        if (next_sel[3]) begin
                            advance = 1'b1;
                            adv_a   = next_sel[2:0];
                        end else if (cont_q && port_sel[3]) begin
                            // Frame wrap: the port mask is re-latched here.
                            mask_d  = ch_mask;
                            advance = 1'b1;
                            adv_a   = port_sel[2:0];
                        end else begin
                            // Continuous wrap onto an empty mask ends quietly.
                            state_d = ST_IDLE;
                            a_d     = 3'd0;
                            en_d    = 1'b0;
                            busy_d  = 1'b0;
                            cnt_d   = '0;
                            done_d  = !cont_q;
                        end
                    end else begin
                        cnt_d  = cnt_inc;
                        tick_d = (cnt_inc == dwell_q);
                    end
                end

`ifdef SCAN_BLANK_EN
                ST_GAP: begin
                    state_d = ST_SCAN;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    tick_d  = (dwell_q == '0);
                end
`endif

                default: begin
                    state_d = ST_IDLE;
                    a_d     = 3'd0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase

            if (advance) begin
                a_d   = adv_a;
                cnt_d = '0;
`ifdef SCAN_BLANK_EN
                state_d = ST_GAP;
                en_d    = 1'b0;
`else
                state_d = ST_SCAN;
                en_d    = 1'b1;
                tick_d  = (dwell_q == '0);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 3'd0;
            en_q    <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            mask_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            mask_q  <= mask_d;
        end
    end

    assign A    = a_q;
    assign EN   = en_q;
    assign tick = tick_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
//
// Directed self-checking bench for scan_sequencer. Each cycle's outputs are
// compared as a packed {A, EN, tick, busy, done} word against hand-derived
// expectations. Honours SCAN_BLANK_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

`ifdef SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode_cont;
    logic [7:0] dwell;
    logic [7:0] ch_mask;
    logic [2:0] A;
    logic       EN;
    logic       tick;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .dwell     (dwell),
        .ch_mask   (ch_mask),
        .A         (A),
        .EN        (EN),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed word layout: {A[2:0], EN, tick, busy, done}
    task automatic expect_out(input string tag, input logic [2:0] ea, input logic een,
                              input logic etick, input logic ebusy, input logic edone);
        check(tag, {25'd0, A, EN, tick, busy, done}, {25'd0, ea, een, etick, ebusy, edone});
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-shot frame checked cycle by cycle. A start pulse is injected at
    // cycle 'poke' (if >= 0) to confirm it is ignored while busy.
    task automatic run_frame(input string tag, input logic [7:0] m, input logic [7:0] dw,
                             input int poke, input int exp_done_cycle);
        int  cyc;
        bit  first;
        ch_mask   = m;
        dwell     = dw;
        mode_cont = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        first = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m[c]) begin
                if (BLANK && !first) begin
                    expect_out({tag, "_gap"}, 3'(c), 1'b0, 1'b0, 1'b1, 1'b0);
                    step();
                    cyc++;
                end
                first = 1'b0;
                for (int d = 0; d <= int'(dw); d++) begin
                    expect_out({tag, "_scan"}, 3'(c), 1'b1, (d == int'(dw)), 1'b1, 1'b0);
                    if (cyc == poke) start = 1'b1;
                    step();
                    start = 1'b0;
                    cyc++;
                end
            end
        end
        check({tag, "_len"}, 32'(cyc + 1), 32'(exp_done_cycle));
        expect_out({tag, "_done"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        expect_out({tag, "_post"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("transaction %s: single frame mask=%02h dwell=%0d checked", tag, m, dw);
    endtask

    initial begin
        int seq [12];
        seq = '{2, 5, 7, 2, 5, 7, 2, 5, 7, 0, 0, 0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
        dwell = 8'd0; ch_mask = 8'd0;
        step(); step();
        expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_out("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("transaction reset: idle state checked");

        // Full mask, dwell=2: done at cycle 25 (32 with blanking gaps).
        run_frame("ff", 8'hFF, 8'd2, -1, BLANK ? 32 : 25);

        // Sparse continuous scan, mask rewritten mid-frame.
        ch_mask = 8'b1010_0100; dwell = 8'd0; mode_cont = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (BLANK && i > 0) begin
                expect_out("sparse_gap", 3'(seq[i]), 1'b0, 1'b0, 1'b1, 1'b0);
                step();
            end
            expect_out("sparse_scan", 3'(seq[i]), 1'b1, 1'b1, 1'b1, 1'b0);
            if (i == 6) ch_mask = 8'h01;
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_out("sparse_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("transaction sparse: continuous scan with mask update checked");

        // Empty-mask start: done next cycle, never busy.
        ch_mask = 8'h00; mode_cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        expect_out("empty_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("empty_post", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("transaction empty: empty mask start checked");

        // Stop on the 2nd dwell cycle of channel 3.
        ch_mask = 8'hFF; dwell = 8'd3; mode_cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (BLANK && c > 0) begin
                expect_out("stop_gap", 3'(c), 1'b0, 1'b0, 1'b1, 1'b0);
                step();
            end
            for (int d = 0; d < 4; d++) begin
                if (c < 3 || d < 2) begin
                    expect_out("stop_scan", 3'(c), 1'b1, (d == 3), 1'b1, 1'b0);
                    if (c == 3 && d == 1) stop = 1'b1;
                    step();
                    stop = 1'b0;
                end
            end
        end
        expect_out("stop_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("stop_idle2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ch_mask = 8'b0011_0000; dwell = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        expect_out("restart", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_out("restart_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("transaction stop: abort and restart checked");

        // Start+stop together from idle.
        ch_mask = 8'hFF; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        expect_out("startstop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("startstop2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("transaction startstop: simultaneous start and stop checked");

        // Start pulsed while busy must not disturb the frame.
        run_frame("busystart", 8'b0011_0000, 8'd1, 1, BLANK ? 6 : 5);

        // Reset mid-scan, held three cycles.
        ch_mask = 8'hFF; dwell = 8'd2; mode_cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("midrst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        step();
        expect_out("after_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("transaction midrst: reset during scan checked");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
